xsw_ingress: RTL and testbench
==============================

XSW_INGRESS -- requirements
Module: xsw_ingress

Interface
REQ-001 SHALL have parameter M, default 2, meaning the number of switch outputs and the width of the one-hot target.
REQ-002 SHALL have parameter DW, default 8, meaning the payload width.
REQ-003 SHALL have parameter DEPTH, default 4, meaning the FIFO entries; it is a power of two and at least 2.
REQ-004 SHALL have derived parameter TW = max(1, clog2(M)), the binary target width, and derived parameter LW = clog2(DEPTH)+1, the level width.
REQ-005 SHALL use one clock; reset is synchronous and active-high.
REQ-006 Port clk, input, 1: clock; all state updates on its rising edge.
REQ-007 Port rst, input, 1: synchronous active-high reset.
REQ-008 Port vld_i, input, 1: upstream request valid.
REQ-009 Port dat_i, input, DW: upstream payload.
REQ-010 Port tgt_i, input, TW: binary destination index.
REQ-011 Port gnt_i, output, 1: upstream accept; a transfer occurs when vld_i & gnt_i.
REQ-012 Port vld_s, output, 1: request towards the switch input.
REQ-013 Port dat_s, output, DW: payload towards the switch.
REQ-014 Port tgt_s, output, M: one-hot destination towards the switch.
REQ-015 Port gnt_s, input, 1: switch grant; a transfer occurs when vld_s & gnt_s.
REQ-016 Port level, output, LW: current FIFO occupancy.
REQ-017 Port err, output, 1: sticky flag for an out-of-range target.
REQ-018 Port err_clr, input, 1: clears err.
REQ-019 Port drop_cnt, output, 8: saturating count of dropped requests.

Function
REQ-020 SHALL store {one-hot tgt, dat} per entry; tgt_i SHALL be decoded to one-hot at write time.
REQ-021 gnt_i SHALL equal !full && !rst, derived from registered state only, never combinationally from vld_i.
REQ-022 vld_s SHALL equal !empty, derived from registered state only, never combinationally from gnt_s; downstream grant may depend combinationally on vld_s.
REQ-023 dat_s/tgt_s SHALL present the head entry; while vld_s=1 and gnt_s=0 they SHALL hold stable.
REQ-024 tgt_s SHALL be exactly one-hot whenever vld_s=1; when vld_s=0 its value is don't-care.
REQ-025 On an accepted transfer with tgt_i < M, the entry SHALL be pushed; vld_s SHALL rise no earlier than the next cycle (1-cycle latency, no bypass).
REQ-026 On an accepted transfer with tgt_i >= M, the transfer SHALL be granted but not stored; err SHALL set next cycle; drop_cnt SHALL increment, saturating at 255.
REQ-027 Pop occurs on vld_s & gnt_s; the read pointer SHALL advance and level SHALL decrement.
REQ-028 Simultaneous push and pop SHALL leave level unchanged, with both pointers advancing.
REQ-029 When full (level==DEPTH), gnt_i=0 and no push occurs, even if a pop happens in the same cycle.
REQ-030 When empty, no pop occurs regardless of gnt_s.
REQ-031 Read and write pointers SHALL wrap modulo DEPTH; full and empty SHALL be distinguished via level or an extra pointer bit.
REQ-032 err_clr SHALL clear err next cycle; if a new drop occurs in the same cycle, set wins and err stays 1; drop_cnt is cleared only by rst.
REQ-033 Ordering SHALL be strict FIFO; no entry may be lost or duplicated.

Reset
REQ-034 While rst=1: gnt_i=0, vld_s=0, level=0, err=0, drop_cnt=0, pointers=0.
REQ-035 rst asserted mid-operation SHALL discard all stored entries in the cycle it is sampled; the first cycle after deassertion SHALL show gnt_i=1, vld_s=0.
REQ-036 Entry contents are not reset; dat_s is don't-care while vld_s=0.

Verification
REQ-037 Single pass (M=4): push dat=0xA5, tgt=2 with gnt_s=1 -> next cycle vld_s=1, dat_s=0xA5, tgt_s=4'b0100; popped that cycle; level returns to 0.
REQ-038 Fill/backpressure (DEPTH=4): push 5 words with gnt_s=0 -> gnt_i=0 after the 4th, level=4, 5th held upstream; raise gnt_s -> words drain in order 1..5.
REQ-039 Concurrent push/pop at level=2 for 10 cycles -> level stays 2, output order matches input order.
REQ-040 Out-of-range (M=3): push tgt=3 -> gnt_i=1, no entry stored, err=1, drop_cnt=1; err_clr with a simultaneous drop -> err=1, drop_cnt=2; err_clr alone -> err=0.
REQ-041 Reset mid-stream at level=3 -> vld_s=0, level=0 after reset; the next push appears alone at the head.
REQ-042 Saturation: 300 out-of-range pushes -> drop_cnt=255, holds.

Source files
------------

// File: rtl/xsw_ingress.sv
// rtl/xsw_ingress.sv - ingress FIFO in front of a switch input, with one-hot target decode and a drop counter
module xsw_ingress #(
  parameter int M     = 2,
  parameter int DW    = 8,
  parameter int DEPTH = 4,
  parameter int TW    = (M > 1) ? $clog2(M) : 1,
  parameter int LW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          vld_i,
  input  logic [DW-1:0] dat_i,
  input  logic [TW-1:0] tgt_i,
  output logic          gnt_i,
  output logic          vld_s,
  output logic [DW-1:0] dat_s,
  output logic [M-1:0]  tgt_s,
  input  logic          gnt_s,
  output logic [LW-1:0] level,
  output logic          err,
  input  logic          err_clr,
  output logic [7:0]    drop_cnt
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int EW = M + DW;

  // Each entry holds the already-decoded one-hot target above the payload.
  logic [EW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [LW-1:0] cnt_q;
  logic          err_q;
  logic [7:0]    drop_q;

  logic          full;
  logic          empty;
  logic          accept;
  logic          in_range;
  logic          push;
  logic          pop;
  logic          drop;
  logic [M-1:0]  tgt_oh;

  assign full  = (cnt_q == LW'(DEPTH));
  assign empty = (cnt_q == '0);

  // Handshakes come only from registered occupancy, so no combinational path from vld_i or gnt_s.
  assign gnt_i = !full && !rst;
  assign vld_s = !empty && !rst;

  assign accept   = vld_i && gnt_i;
  assign in_range = (32'(tgt_i) < 32'(M));
  assign push     = accept && in_range;
  assign drop     = accept && !in_range;
  assign pop      = vld_s && gnt_s;

  // Binary target to one-hot; an out-of-range index yields zero but is never stored.
  always_comb begin
    tgt_oh = '0;
    for (int i = 0; i < M; i++) begin
      if (32'(tgt_i) == 32'(i)) tgt_oh[i] = 1'b1;
    end
  end

  assign {tgt_s, dat_s} = mem[rd_ptr];

  // Outputs are forced to their idle values for as long as reset is held.
  assign level    = rst ? '0 : cnt_q;
  assign err      = err_q && !rst;
  assign drop_cnt = rst ? '0 : drop_q;

  // Entry storage is written on push and never reset.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {tgt_oh, dat_i};
  end

  // Pointers wrap naturally at the power-of-two depth; occupancy separates full from empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + LW'(1);
        2'b01:   cnt_q <= cnt_q - LW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Sticky error where a new drop beats a clear, and a drop counter that saturates at 255.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q  <= 1'b0;
      drop_q <= '0;
    end else begin
      if (drop)         err_q <= 1'b1;
      else if (err_clr) err_q <= 1'b0;
      if (drop && (drop_q != 8'hFF)) drop_q <= drop_q + 8'd1;
    end
  end

endmodule

// File: tb/tb_xsw_ingress.sv
// tb/tb_xsw_ingress.sv - randomized scoreboard bench for xsw_ingress against a queue reference model
module tb_xsw_ingress;
  localparam int M     = 3;
  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int TW    = 2;
  localparam int LW    = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          vld_i;
  logic [DW-1:0] dat_i;
  logic [TW-1:0] tgt_i;
  logic          gnt_i;
  logic          vld_s;
  logic [DW-1:0] dat_s;
  logic [M-1:0]  tgt_s;
  logic          gnt_s;
  logic [LW-1:0] level;
  logic          err;
  logic          err_clr;
  logic [7:0]    drop_cnt;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [M-1:0]  oh;
    logic [DW-1:0] d;
  } ent_t;

  ent_t exp_q[$];
  int   m_drop = 0;
  bit   m_err  = 1'b0;

  always #5 clk = ~clk;

  xsw_ingress #(.M(M), .DW(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .vld_i(vld_i), .dat_i(dat_i), .tgt_i(tgt_i), .gnt_i(gnt_i),
    .vld_s(vld_s), .dat_s(dat_s), .tgt_s(tgt_s), .gnt_s(gnt_s), .level(level),
    .err(err), .err_clr(err_clr), .drop_cnt(drop_cnt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of stimulus right after the falling edge.
  task automatic cyc(input bit v, input logic [DW-1:0] d, input logic [TW-1:0] t,
                     input bit g, input bit c, input bit r);
    @(negedge clk);
    vld_i = v; dat_i = d; tgt_i = t; gnt_s = g; err_clr = c; rst = r;
  endtask

  // Monitor: samples just before each rising edge, compares against the model, then advances it.
  initial begin
    int   sz;
    bit   mg;
    bit   dropped;
    bit   popped;
    ent_t e;
    forever begin
      @(negedge clk);
      #3;
      sz = exp_q.size();
      if (rst) begin
        chk("rst_gnt_i", gnt_i, 0);
        chk("rst_vld_s", vld_s, 0);
        chk("rst_level", level, 0);
        chk("rst_err", err, 0);
        chk("rst_drop_cnt", drop_cnt, 0);
        exp_q.delete();
        m_drop = 0;
        m_err  = 1'b0;
      end else begin
        mg = (sz < DEPTH);
        chk("gnt_i", gnt_i, mg);
        chk("vld_s", vld_s, sz != 0);
        chk("level", level, sz);
        chk("err", err, m_err);
        chk("drop_cnt", drop_cnt, m_drop);
        if (sz != 0) begin
          chk("dat_s", dat_s, exp_q[0].d);
          chk("tgt_s", tgt_s, exp_q[0].oh);
        end
        popped  = (sz != 0) && gnt_s;
        dropped = 1'b0;
        if (vld_i && mg) begin
          if (int'(tgt_i) < M) begin
            e.oh = M'(1) << tgt_i;
            e.d  = dat_i;
            exp_q.push_back(e);
          end else begin
            dropped = 1'b1;
          end
        end
        if (popped) void'(exp_q.pop_front());
        if (dropped) begin
          m_err = 1'b1;
          if (m_drop < 255) m_drop++;
        end else if (err_clr) begin
          m_err = 1'b0;
        end
      end
    end
  end

  initial begin
    rst = 1'b1; vld_i = 1'b0; dat_i = '0; tgt_i = '0; gnt_s = 1'b0; err_clr = 1'b0;
    repeat (3) cyc(0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0);

    // Single pass through the FIFO.
    cyc(1, 8'hA5, 2, 1, 0, 0);
    repeat (3) cyc(0, 0, 0, 1, 0, 0);

    // Fill to full with backpressure, hold the fifth word, then drain.
    for (int i = 1; i <= 4; i++) cyc(1, 8'(i), TW'(i % M), 0, 0, 0);
    repeat (3) cyc(1, 8'd5, 1, 0, 0, 0);
    cyc(1, 8'd5, 1, 1, 0, 0);
    cyc(1, 8'd5, 1, 1, 0, 0);
    repeat (6) cyc(0, 0, 0, 1, 0, 0);

    // Concurrent push and pop at level 2.
    cyc(1, 8'h10, 0, 0, 0, 0);
    cyc(1, 8'h11, 1, 0, 0, 0);
    for (int i = 0; i < 10; i++) cyc(1, 8'(8'h20 + i), TW'(i % M), 1, 0, 0);
    repeat (4) cyc(0, 0, 0, 1, 0, 0);

    // Out-of-range target, clear racing a new drop, then a lone clear.
    cyc(1, 8'h33, 3, 0, 0, 0);
    cyc(1, 8'h34, 3, 0, 1, 0);
    cyc(0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0, 0);

    // Reset in the middle of a stream at level 3.
    for (int i = 0; i < 3; i++) cyc(1, 8'(8'h40 + i), TW'(i), 0, 0, 0);
    cyc(1, 8'h4F, 0, 0, 0, 1);
    cyc(1, 8'h50, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    repeat (2) cyc(0, 0, 0, 1, 0, 0);

    // Randomized traffic with occasional clears and resets.
    for (int i = 0; i < 400; i++)
      cyc($urandom_range(0, 1), 8'($urandom), TW'($urandom_range(0, 3)), $urandom_range(0, 1),
          ($urandom_range(0, 15) == 0), ($urandom_range(0, 99) == 0));
    cyc(0, 0, 0, 1, 0, 0);

    // Drop counter saturation.
    for (int i = 0; i < 300; i++) cyc(1, 8'($urandom), 3, $urandom_range(0, 1), 0, 0);
    repeat (6) cyc(0, 0, 0, 1, 0, 0);
    #3;
    chk("drop_cnt_saturated", drop_cnt, 255);
    chk("err_after_saturation", err, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
